// File: rtl/text_vram_axi_regs_pkg.sv
// text_vram_pkg: shared constants, types and helpers for the text-mode VRAM register block.
package text_vram_pkg;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 12;
  localparam int IDX_W    = ADDR_W - 2;
  localparam int NUM_REGS = 601;
  localparam int CTRL_IDX = 600;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  // control word field positions (each field is FIELD_W bits wide)
  localparam int FIELD_W  = 4;
  localparam int BG_B_LSB = 1;
  localparam int BG_G_LSB = 5;
  localparam int BG_R_LSB = 9;
  localparam int FG_B_LSB = 13;
  localparam int FG_G_LSB = 17;
  localparam int FG_R_LSB = 21;
  typedef logic [DATA_W-1:0] vram_word_t;
  typedef logic [IDX_W-1:0]  vram_idx_t;
  function automatic logic in_range(vram_idx_t idx);
    return idx < IDX_W'(NUM_REGS);
  endfunction
  function automatic vram_word_t apply_strb(vram_word_t old_w, vram_word_t new_w, logic [DATA_W/8-1:0] strb);
    apply_strb = old_w;
    for (int b = 0; b < DATA_W/8; b++)
      if (strb[b]) apply_strb[8*b +: 8] = new_w[8*b +: 8];
  endfunction
endpackage

// File: rtl/text_vram_axi_regs_if.sv
// text_vram_axi_regs_if: AXI4-Lite channel bundle with master/slave views.
interface text_vram_axi_regs_if;
  import text_vram_pkg::*;
  logic [ADDR_W-1:0]   awaddr;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;
  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/text_vram_axi_regs.sv
// text_vram_axi_regs: AXI4-Lite slave holding 600 text words plus a colour control word,
// with the whole array exposed continuously to the pixel path.
module text_vram_axi_regs
  import text_vram_pkg::*;
(
  input  logic                 axi_aclk,
  input  logic                 axi_aresetn,
  text_vram_axi_regs_if.slave  axi,
  output vram_word_t           vga_ram [NUM_REGS]
);
  vram_word_t          mem_q [NUM_REGS];
  logic                aw_full_q, w_full_q, bvalid_q, rvalid_q;
  vram_idx_t           aw_idx_q;
  vram_word_t          wdata_q, rdata_q, wr_word_d;
  logic [DATA_W/8-1:0] wstrb_q;
  logic [1:0]          bresp_q, rresp_q;
  logic                aw_hs, w_hs, ar_hs, commit, aw_ok, ar_ok;
  vram_idx_t           ar_idx;
  logic [3:0]          unused_addr_lsbs;
  assign unused_addr_lsbs = {axi.awaddr[1:0], axi.araddr[1:0]};
  assign axi.awready = !aw_full_q;
  assign axi.wready  = !w_full_q;
  assign axi.arready = !rvalid_q;
  assign axi.bvalid  = bvalid_q;
  assign axi.bresp   = bresp_q;
  assign axi.rvalid  = rvalid_q;
  assign axi.rdata   = rdata_q;
  assign axi.rresp   = rresp_q;
  assign vga_ram     = mem_q;
  assign aw_hs  = axi.awvalid && !aw_full_q;
  assign w_hs   = axi.wvalid && !w_full_q;
  assign ar_hs  = axi.arvalid && !rvalid_q;
  // a new commit waits until the previous response has been taken
  assign commit = aw_full_q && w_full_q && !bvalid_q;
  assign ar_idx = axi.araddr[ADDR_W-1:2];
  assign aw_ok  = in_range(aw_idx_q);
  assign ar_ok  = in_range(ar_idx);
  assign wr_word_d = aw_ok ? apply_strb(mem_q[aw_idx_q], wdata_q, wstrb_q) : '0;
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      for (int i = 0; i < NUM_REGS; i++) mem_q[i] <= '0;
      aw_full_q <= 1'b0;
      w_full_q  <= 1'b0;
      aw_idx_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      if (aw_hs) begin
        aw_full_q <= 1'b1;
        aw_idx_q  <= axi.awaddr[ADDR_W-1:2];
      end
      if (w_hs) begin
        w_full_q <= 1'b1;
        wdata_q  <= axi.wdata;
        wstrb_q  <= axi.wstrb;
      end
      if (commit) begin
        if (aw_ok) mem_q[aw_idx_q] <= wr_word_d;
        aw_full_q <= 1'b0;
        w_full_q  <= 1'b0;
        bvalid_q  <= 1'b1;
        bresp_q   <= aw_ok ? RESP_OKAY : RESP_SLVERR;
      end else if (bvalid_q && axi.bready) begin
        bvalid_q <= 1'b0;
      end
      // reads sample the array before any same-edge commit lands
      if (ar_hs) begin
        rvalid_q <= 1'b1;
        rdata_q  <= ar_ok ? mem_q[ar_idx] : '0;
        rresp_q  <= ar_ok ? RESP_OKAY : RESP_SLVERR;
      end else if (rvalid_q && axi.rready) begin
        rvalid_q <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_text_vram_axi_regs.sv
// tb_text_vram_axi_regs: directed self-checking bench for the text VRAM AXI4-Lite block.
module tb_text_vram_axi_regs;
  import text_vram_pkg::*;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  int         checks = 0;
  int         failures = 0;
  vram_word_t vga_ram [NUM_REGS];
  vram_word_t rd;
  logic [1:0] rsp;
  text_vram_axi_regs_if bus ();
  text_vram_axi_regs dut (
    .axi_aclk    (clk),
    .axi_aresetn (rst_n),
    .axi         (bus.slave),
    .vga_ram     (vga_ram)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic do_write(input logic [11:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          output logic [1:0] resp);
    logic aw_hs, w_hs;
    int n;
    bus.awaddr = addr; bus.awvalid = 1'b1;
    bus.wdata = data; bus.wstrb = strb; bus.wvalid = 1'b1;
    bus.bready = 1'b1;
    n = 0;
    while ((bus.awvalid || bus.wvalid) && n < 20) begin
      aw_hs = bus.awvalid && bus.awready;
      w_hs  = bus.wvalid && bus.wready;
      tick();
      if (aw_hs) bus.awvalid = 1'b0;
      if (w_hs) bus.wvalid = 1'b0;
      n++;
    end
    n = 0;
    while (!bus.bvalid && n < 20) begin
      tick();
      n++;
    end
    chk("wr_bvalid_seen", {31'b0, bus.bvalid}, 32'd1);
    resp = bus.bresp;
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    tick();
  endtask
  task automatic do_read(input logic [11:0] addr, output logic [31:0] data, output logic [1:0] resp);
    int n;
    bus.araddr = addr; bus.arvalid = 1'b1; bus.rready = 1'b1;
    n = 0;
    while (!bus.arready && n < 20) begin
      tick();
      n++;
    end
    tick();
    bus.arvalid = 1'b0;
    chk("rd_rvalid_seen", {31'b0, bus.rvalid}, 32'd1);
    data = bus.rdata;
    resp = bus.rresp;
    tick();
  endtask
  initial begin
    bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
    bus.bready = 1'b0; bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
    #2;
    chk("rst_awready", {31'b0, bus.awready}, 32'd1);
    chk("rst_wready", {31'b0, bus.wready}, 32'd1);
    chk("rst_arready", {31'b0, bus.arready}, 32'd1);
    chk("rst_bvalid", {31'b0, bus.bvalid}, 32'd0);
    chk("rst_rvalid", {31'b0, bus.rvalid}, 32'd0);
    chk("rst_rdata", bus.rdata, 32'd0);
    chk("rst_bresp", {30'b0, bus.bresp}, 32'd0);
    chk("rst_vram600", vga_ram[600], 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    // AW+W same cycle: commit at next edge, bvalid visible after it
    bus.awaddr = 12'h004; bus.awvalid = 1'b1;
    bus.wdata = 32'h41424344; bus.wstrb = 4'hF; bus.wvalid = 1'b1; bus.bready = 1'b1;
    tick();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    chk("t1_bvalid_early", {31'b0, bus.bvalid}, 32'd0);
    chk("t1_vram1_early", vga_ram[1], 32'd0);
    tick();
    chk("t1_bvalid", {31'b0, bus.bvalid}, 32'd1);
    chk("t1_bresp", {30'b0, bus.bresp}, {30'b0, RESP_OKAY});
    chk("t1_vram1", vga_ram[1], 32'h41424344);
    tick();
    chk("t1_bvalid_clr", {31'b0, bus.bvalid}, 32'd0);
    do_read(12'h004, rd, rsp);
    chk("t1_rdata", rd, 32'h41424344);
    chk("t1_rresp", {30'b0, rsp}, {30'b0, RESP_OKAY});
    // W leads AW by three cycles
    bus.wdata = 32'h00FFFFFE; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    tick();
    bus.wvalid = 1'b0;
    chk("t2_wready_low", {31'b0, bus.wready}, 32'd0);
    chk("t2_awready_high", {31'b0, bus.awready}, 32'd1);
    tick(); tick();
    chk("t2_no_commit", {31'b0, bus.bvalid}, 32'd0);
    bus.awaddr = 12'h960; bus.awvalid = 1'b1;
    tick();
    bus.awvalid = 1'b0;
    chk("t2_bvalid_early", {31'b0, bus.bvalid}, 32'd0);
    tick();
    chk("t2_bvalid", {31'b0, bus.bvalid}, 32'd1);
    chk("t2_vram600", vga_ram[600], 32'h00FFFFFE);
    tick();
    chk("t2_single_commit", {31'b0, bus.bvalid}, 32'd0);
    // partial strobes
    do_write(12'h008, 32'h11223344, 4'hF, rsp);
    do_write(12'h008, 32'hAABBCCDD, 4'b0101, rsp);
    chk("t3_strb_resp", {30'b0, rsp}, {30'b0, RESP_OKAY});
    chk("t3_strb_word", vga_ram[2], 32'h11BB33DD);
    do_write(12'h008, 32'hFFFFFFFF, 4'b0000, rsp);
    chk("t3_zero_strb_resp", {30'b0, rsp}, {30'b0, RESP_OKAY});
    chk("t3_zero_strb_word", vga_ram[2], 32'h11BB33DD);
    // out of range index 601
    do_write(12'h964, 32'hDEADBEEF, 4'hF, rsp);
    chk("t4_wr_slverr", {30'b0, rsp}, {30'b0, RESP_SLVERR});
    chk("t4_vram600_kept", vga_ram[600], 32'h00FFFFFE);
    do_read(12'h964, rd, rsp);
    chk("t4_rd_zero", rd, 32'd0);
    chk("t4_rd_slverr", {30'b0, rsp}, {30'b0, RESP_SLVERR});
    do_read(12'h962, rd, rsp);
    chk("t4_lsbs_ignored", rd, 32'h00FFFFFE);
    // back-pressure on B with a second write buffered
    bus.bready = 1'b0;
    bus.awaddr = 12'h00C; bus.awvalid = 1'b1;
    bus.wdata = 32'hCAFEF00D; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    tick();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    tick();
    chk("t5_b1_valid", {31'b0, bus.bvalid}, 32'd1);
    bus.awaddr = 12'h010; bus.awvalid = 1'b1;
    bus.wdata = 32'h12345678; bus.wvalid = 1'b1;
    tick();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    chk("t5_awready_low", {31'b0, bus.awready}, 32'd0);
    chk("t5_wready_low", {31'b0, bus.wready}, 32'd0);
    repeat (7) tick();
    chk("t5_b1_held", {31'b0, bus.bvalid}, 32'd1);
    chk("t5_b1_resp", {30'b0, bus.bresp}, {30'b0, RESP_OKAY});
    chk("t5_vram3", vga_ram[3], 32'hCAFEF00D);
    chk("t5_vram4_stalled", vga_ram[4], 32'd0);
    bus.bready = 1'b1;
    tick();
    chk("t5_b1_taken", {31'b0, bus.bvalid}, 32'd0);
    chk("t5_vram4_still", vga_ram[4], 32'd0);
    tick();
    chk("t5_b2_valid", {31'b0, bus.bvalid}, 32'd1);
    chk("t5_vram4", vga_ram[4], 32'h12345678);
    chk("t5_awready_back", {31'b0, bus.awready}, 32'd1);
    tick();
    chk("t5_b2_taken", {31'b0, bus.bvalid}, 32'd0);
    // back-pressure on R
    bus.rready = 1'b0;
    bus.araddr = 12'h00C; bus.arvalid = 1'b1;
    tick();
    bus.arvalid = 1'b0;
    chk("t6_rvalid", {31'b0, bus.rvalid}, 32'd1);
    chk("t6_rdata", bus.rdata, 32'hCAFEF00D);
    chk("t6_arready_low", {31'b0, bus.arready}, 32'd0);
    bus.araddr = 12'h004;
    repeat (5) tick();
    chk("t6_rdata_stable", bus.rdata, 32'hCAFEF00D);
    chk("t6_rvalid_held", {31'b0, bus.rvalid}, 32'd1);
    chk("t6_arready_still_low", {31'b0, bus.arready}, 32'd0);
    bus.rready = 1'b1;
    tick();
    chk("t6_rvalid_clr", {31'b0, bus.rvalid}, 32'd0);
    chk("t6_arready_back", {31'b0, bus.arready}, 32'd1);
    // read and commit to the same word on the same edge
    bus.wdata = 32'h99999999; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    tick();
    bus.wvalid = 1'b0;
    bus.awaddr = 12'h004; bus.awvalid = 1'b1;
    tick();
    bus.awvalid = 1'b0;
    bus.araddr = 12'h004; bus.arvalid = 1'b1; bus.rready = 1'b0;
    tick();
    bus.arvalid = 1'b0;
    chk("t7_read_old", bus.rdata, 32'h41424344);
    chk("t7_vram1_new", vga_ram[1], 32'h99999999);
    chk("t7_bvalid", {31'b0, bus.bvalid}, 32'd1);
    bus.rready = 1'b1;
    tick();
    // reset with W buffered
    bus.wdata = 32'h77777777; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    tick();
    bus.wvalid = 1'b0;
    chk("t8_w_buffered", {31'b0, bus.wready}, 32'd0);
    rst_n = 1'b0;
    #2;
    chk("t8_vram1_zero", vga_ram[1], 32'd0);
    chk("t8_vram600_zero", vga_ram[600], 32'd0);
    chk("t8_wready", {31'b0, bus.wready}, 32'd1);
    chk("t8_awready", {31'b0, bus.awready}, 32'd1);
    chk("t8_bvalid", {31'b0, bus.bvalid}, 32'd0);
    tick();
    rst_n = 1'b1;
    bus.awaddr = 12'h004; bus.awvalid = 1'b1;
    tick();
    bus.awvalid = 1'b0;
    tick(); tick();
    chk("t8_no_commit", {31'b0, bus.bvalid}, 32'd0);
    chk("t8_vram1_kept", vga_ram[1], 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
